multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back over several clocks, producing every datapath select and strobe. Drives the 3-bit ALUOp consumed by the ALU controller: 000 add, 001 sub, 010 funct-decoded, 101 slt. Handles variable-latency memory through a ready handshake with a timeout.

---
 rtl/multicycle_pkg.sv | 42 ++++
 rtl/multicycle_ctrl_if.sv | 46 ++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes
// and the ALUOp codes understood by the ALU controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // States that wait on the memory ready handshake.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. branch_ne_o exists only when
// BNE_EN is defined.
interface multicycle_ctrl_if;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       mem_to_reg_o;
    logic       reg_dst_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] pc_source_o;
    logic [2:0] ALUOp_o;
    logic       illegal_o;
    logic       mem_err_o;
    logic [3:0] state_o;
`ifdef BNE_EN
    logic       branch_ne_o;
`endif

    modport master (
        input  opcode_i, funct_i, mem_ready_i,
`ifdef BNE_EN
        output branch_ne_o,
`endif
        output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, pc_source_o, ALUOp_o, illegal_o, mem_err_o, state_o
    );

    modport slave (
        output opcode_i, funct_i, mem_ready_i,
`ifdef BNE_EN
        input  branch_ne_o,
`endif
        input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, pc_source_o, ALUOp_o, illegal_o, mem_err_o, state_o
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags a
// timeout when the count reaches MAX_WAIT (MAX_WAIT = 0 disables it).
module mem_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_wait_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    logic [WAIT_W-1:0] count_q;
    logic              stalled;

    assign stalled   = in_wait_i && !mem_ready_i;
    assign timeout_o = (MAX_WAIT != 0) && stalled && (count_q == WAIT_W'(MAX_WAIT));

    // Saturates rather than wrapping so a disabled timeout never aliases.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (stalled && !timeout_o) begin
            if (count_q != '1) begin
                count_q <= count_q + WAIT_W'(1);
            end
        end else begin
            count_q <= '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. Define BNE_EN to add
// bne support and the branch_ne_o output.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    state_t state_q;
    state_t decode_next;
    logic   op_legal;
    logic   timeout;

    mem_wait_timer #(
        .WAIT_W  (WAIT_W),
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_wait_i  (is_wait_state(state_q)),
        .mem_ready_i(bus.mem_ready_i),
        .timeout_o  (timeout)
    );

    always_comb begin
        op_legal    = 1'b1;
        decode_next = S_FETCH;
        case (bus.opcode_i)
            OP_LW, OP_SW:    decode_next = S_MEMADR;
            OP_RTYPE:        decode_next = (bus.funct_i == FUNCT_JR) ? S_JR : S_EXEC;
            OP_BEQ:          decode_next = S_BRANCH;
`ifdef BNE_EN
            OP_BNE:          decode_next = S_BRANCH;
`endif
            OP_J:            decode_next = S_JUMP;
            OP_ADDI, OP_SLTI: decode_next = S_IEXEC;
            default:         op_legal    = 1'b0;
        endcase
    end

    // A timeout overrides every transition and aborts back to IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else if (timeout) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH:  if (bus.mem_ready_i) state_q <= S_DECODE;
                S_DECODE: state_q <= decode_next;
                S_MEMADR: state_q <= (bus.opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (bus.mem_ready_i) state_q <= S_MEMWB;
                S_MEMWR:  if (bus.mem_ready_i) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_RWB;
                S_IEXEC:  state_q <= S_IWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JR:
                          state_q <= S_FETCH;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.state_o   = state_q;
    assign bus.mem_err_o = timeout;

    always_comb begin
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.i_or_d_o        = 1'b0;
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'b00;
        bus.pc_source_o     = 2'b00;
        bus.ALUOp_o         = ALUOP_ADD;
        bus.illegal_o       = 1'b0;
`ifdef BNE_EN
        bus.branch_ne_o     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_src_b_o = 2'b01;
                bus.ir_write_o  = bus.mem_ready_i;
                bus.pc_write_o  = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.alu_src_b_o = 2'b11;
                bus.illegal_o   = !op_legal;
            end
            S_MEMADR: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_read_o = 1'b1;
                bus.i_or_d_o   = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg_o = 1'b1;
                bus.reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write_o = 1'b1;
                bus.i_or_d_o    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a_o = 1'b1;
                bus.ALUOp_o     = ALUOP_FUNCT;
            end
            S_RWB: begin
                bus.reg_dst_o   = 1'b1;
                bus.reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a_o     = 1'b1;
                bus.ALUOp_o         = ALUOP_SUB;
                bus.pc_write_cond_o = 1'b1;
                bus.pc_source_o     = 2'b01;
`ifdef BNE_EN
                bus.branch_ne_o     = (bus.opcode_i == OP_BNE);
`endif
            end
            S_JUMP: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = 2'b10;
            end
            S_IEXEC: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
                bus.ALUOp_o     = (bus.opcode_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IWB: begin
                bus.reg_write_o = 1'b1;
            end
            S_JR: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
